// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- architectural register file feeding the ALU.
//
// 2**ADDR_WIDTH registers of DATA_WIDTH bits. Register 0 is hardwired to zero.
// Two asynchronous read ports (RD1 -> ALUOP1, RD2 -> operand mux / ALUOP2) and
// one synchronous write port for write-back data.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a write presented in the current cycle is forwarded
//   combinationally to any read port addressing the same (non-zero) register.
//   a0 is never forwarded. Storage behaviour is identical in both builds.
//
// Ports:
//   clk    in   1           system clock, writes on rising edge
//   rst_n  in   1           asynchronous active-low reset, clears all registers
//   AD1    in   ADDR_WIDTH  read address, port 1
//   AD2    in   ADDR_WIDTH  read address, port 2
//   AD3    in   ADDR_WIDTH  write address
//   WE3    in   1           write enable
//   WD3    in   DATA_WIDTH  write data
//   RD1    out  DATA_WIDTH  read data, port 1
//   RD2    out  DATA_WIDTH  read data, port 2
//   a0     out  DATA_WIDTH  continuous copy of register A0_INDEX
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int A0_INDEX   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] AD1,
    input  logic [ADDR_WIDTH-1:0] AD2,
    input  logic [ADDR_WIDTH-1:0] AD3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR  = A0_INDEX[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic                  write_en_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Writes to register 0 are dropped here, so entry 0 holds its reset zero forever.
    assign write_en_s = WE3 && (AD3 != ZERO_ADDR);

    // Storage: async clear, single write port committed on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (write_en_s) begin
            regs_r[AD3] <= WD3;
        end
    end

    // Read port 1: combinational lookup with optional same-cycle forward.
    always_comb begin
        rd1_s = ZERO_DATA;
        if (AD1 == ZERO_ADDR) begin
            rd1_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (rst_n && write_en_s && (AD1 == AD3)) begin
            rd1_s = WD3;
`endif
        end else begin
            rd1_s = regs_r[AD1];
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rd2_s = ZERO_DATA;
        if (AD2 == ZERO_ADDR) begin
            rd2_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (rst_n && write_en_s && (AD2 == AD3)) begin
            rd2_s = WD3;
`endif
        end else begin
            rd2_s = regs_r[AD2];
        end
    end

    assign RD1 = rd1_s;
    assign RD2 = rd2_s;
    // a0 reflects committed storage only; it is never forwarded.
    assign a0  = regs_r[A0_ADDR];

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file.
// Reference model: a plain 32-entry array updated with the write rule at each
// rising edge; expected reads come from the array (plus forwarding when the
// REGFILE_BYPASS_EN build is selected).
// -----------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [4:0]  ad3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a0;

    logic [31:0] ref_regs [32];
    int          tests;
    int          fails;

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .A0_INDEX  (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .AD1  (ad1),
        .AD2  (ad2),
        .AD3  (ad3),
        .WE3  (we3),
        .WD3  (wd3),
        .RD1  (rd1),
        .RD2  (rd2),
        .a0   (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected value on a read port given current inputs and model contents.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && ad3 != 5'd0 && a == ad3) return wd3;
`endif
        return ref_regs[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, rd1, exp_rd(ad1));
        check({tag, "_rd2"}, rd2, exp_rd(ad2));
        check({tag, "_a0"},  a0,  rst_n ? ref_regs[10] : 32'd0);
    endtask

    task automatic set_in(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] a3, input logic we, input logic [31:0] wd);
        ad1 = a1; ad2 = a2; ad3 = a3; we3 = we; wd3 = wd;
    endtask

    // One rising edge: the model commits with the same rule the spec states.
    task automatic edge_commit();
        @(posedge clk);
        if (rst_n && we3 && ad3 != 5'd0) ref_regs[ad3] = wd3;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_clear();
        rst_n = 1'b0;
        set_in(5'd5, 5'd10, 5'd7, 1'b1, 32'hCAFE_F00D);

        // Reset state: everything reads zero, writes during reset are ignored.
        #3;
        check_ports("reset_init");
        edge_commit();
        check_ports("reset_write_ignored");
        check("reset_x7_rd", rd1, 32'd0);
        @(negedge clk);
        set_in(5'd7, 5'd0, 5'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_x7_after", rd1, 32'd0);

        // Basic write/read.
        @(negedge clk);
        set_in(5'd7, 5'd7, 5'd7, 1'b1, 32'h0000_0123);
        edge_commit();
        set_in(5'd7, 5'd7, 5'd0, 1'b0, 32'd0);
        #1;
        check("basic_rd1", rd1, 32'h0000_0123);
        check("basic_rd2", rd2, 32'h0000_0123);

        // x0 protection.
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        edge_commit();
        check("x0_rd1", rd1, 32'd0);
        check("x0_rd2", rd2, 32'd0);

        // Write disable.
        @(negedge clk);
        set_in(5'd3, 5'd3, 5'd3, 1'b1, 32'h11);
        edge_commit();
        @(negedge clk);
        set_in(5'd3, 5'd3, 5'd3, 1'b0, 32'h22);
        edge_commit();
        check("wdis_rd2", rd2, 32'h11);

        // a0 mirror.
        @(negedge clk);
        set_in(5'd10, 5'd0, 5'd10, 1'b1, 32'h0000_002A);
        #1;
        check("a0_before", a0, 32'd0);
        edge_commit();
        check("a0_after", a0, 32'h0000_002A);

        // Same-cycle read/write of x9.
        @(negedge clk);
        set_in(5'd9, 5'd0, 5'd9, 1'b1, 32'h5);
        edge_commit();
        @(negedge clk);
        set_in(5'd9, 5'd9, 5'd9, 1'b1, 32'h6);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_pre", rd1, 32'h6);
`else
        check("same_cycle_pre", rd1, 32'h5);
`endif
        check_ports("same_cycle_model");
        edge_commit();
        check("same_cycle_post", rd1, 32'h6);
        // AD3=0 never forwards.
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 32'h7777_7777);
        #1;
        check("same_cycle_x0", rd1, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            set_in(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            if (n % 7 == 0) ad2 = ad1;
            if (n % 5 == 0) ad1 = ad3;
            if (n % 11 == 0) ad3 = 5'd10;
            #1;
            check_ports("rand_pre");
            edge_commit();
            check_ports("rand_post");
        end

        // Reset mid-cycle: x5 written, then rst_n falls between edges.
        @(negedge clk);
        set_in(5'd5, 5'd6, 5'd5, 1'b1, 32'hDEAD_BEEF);
        edge_commit();
        @(negedge clk);
        set_in(5'd5, 5'd6, 5'd6, 1'b1, 32'h1234_5678);
        #1;
        check("midrst_pre", rd1, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_rd1", rd1, 32'd0);
        check_ports("midrst_ports");
        edge_commit();
        check("midrst_lost_write", rd2, 32'd0);
        @(negedge clk);
        set_in(5'd5, 5'd6, 5'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        #1;
        check_ports("midrst_release");
        // First edge after release can write.
        @(negedge clk);
        set_in(5'd6, 5'd5, 5'd6, 1'b1, 32'hA5A5_5A5A);
        edge_commit();
        check("post_rst_write", rd1, 32'hA5A5_5A5A);
        check_ports("post_rst_ports");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
